// File: rtl/bcd_up_counter_pkg.sv
// -----------------------------------------------------------------------------
// bcd_up_counter_pkg
// Shared BCD constants and digit type for the BCD up/down counter family.
// Contents:
//   BCD_W        width of one BCD digit
//   bcd_digit_t  one BCD digit (codes A..F are representable but illegal)
//   BCD_MAX      largest legal digit value (9)
//   BCD_ZERO     digit value zero
//   bcd_at_max() true when a digit is 9 or an illegal code above 9
// -----------------------------------------------------------------------------
package bcd_up_counter_pkg;

   localparam int BCD_W = 4;

   typedef logic [BCD_W-1:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX  = 4'd9;
   localparam bcd_digit_t BCD_ZERO = 4'd0;

   // Illegal codes behave like 9 so that an out-of-range load recovers
   // on the next count.
   function automatic logic bcd_at_max(input bcd_digit_t d);
      return (d >= BCD_MAX);
   endfunction

endpackage

// File: rtl/bcd_up_counter_if.sv
// -----------------------------------------------------------------------------
// bcd_up_counter_if
// Control/data bundle of the BCD up-counter (74161-style control set).
// Parameter: DIGITS - number of BCD digits; D/Q are 4*DIGITS bits wide.
// Signals:
//   Ld   synchronous load, active-low
//   CTP  count enable (parallel)
//   CTT  count enable (trickle), also gates CO
//   D    load value, digit 0 in bits [3:0]
//   Q    registered counter value
//   CO   combinational ripple carry to the next stage
//   OVF  registered sticky overflow flag
// Modports: master drives controls and reads results; slave is the counter.
// -----------------------------------------------------------------------------
interface bcd_up_counter_if #(
   parameter int DIGITS = 2
);

   localparam int QW = 4 * DIGITS;

   logic          Ld;
   logic          CTP;
   logic          CTT;
   logic [QW-1:0] D;
   logic [QW-1:0] Q;
   logic          CO;
   logic          OVF;

   modport master (
      output Ld, CTP, CTT, D,
      input  Q, CO, OVF
   );

   modport slave (
      input  Ld, CTP, CTT, D,
      output Q, CO, OVF
   );

endinterface

// File: rtl/bcd_up_counter_digit_up.sv
// -----------------------------------------------------------------------------
// bcd_digit_up
// One BCD digit of the up-counter: loadable, increments on inc_i, wraps 9->0.
// A digit holding an illegal code (A..F) is treated as 9 when incremented.
// Ports:
//   CP          clock, rising edge
//   CR          asynchronous reset, active-high (digit -> 0)
//   load_i      synchronous load strobe, active-high, wins over inc_i
//   load_val_i  value loaded (copied verbatim, illegal codes included)
//   inc_i       increment this digit on the next edge
//   q_o         registered digit value
//   is_max_o    digit is 9 or above (a carry out is produced when incremented)
// -----------------------------------------------------------------------------
module bcd_digit_up
   import bcd_up_counter_pkg::*;
(
   input  logic       CP,
   input  logic       CR,
   input  logic       load_i,
   input  bcd_digit_t load_val_i,
   input  logic       inc_i,
   output bcd_digit_t q_o,
   output logic       is_max_o
);

   bcd_digit_t q_q;
   bcd_digit_t q_d;

   always_comb begin
      q_d = q_q;
      if (load_i) begin
         q_d = load_val_i;
      end else if (inc_i) begin
         q_d = bcd_at_max(q_q) ? BCD_ZERO : (q_q + 4'd1);
      end
   end

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         q_q <= BCD_ZERO;
      end else begin
         q_q <= q_d;
      end
   end

   assign q_o      = q_q;
   assign is_max_o = bcd_at_max(q_q);

endmodule

// File: rtl/bcd_up_counter.sv
// -----------------------------------------------------------------------------
// bcd_up_counter
// Cascadable N-digit BCD up-counter with 74161-style controls, a sticky
// overflow flag and an optional saturate mode.
// Parameter: DIGITS - number of BCD digits (1..4).
// Ports:
//   CP   clock, rising edge
//   CR   asynchronous reset, active-high (Q=0, OVF=0)
//   bus  bcd_up_counter_if.slave: Ld, CTP, CTT, D in; Q, CO, OVF out
// Priority at each edge: load (Ld=0), then count (CTP&CTT), then hold.
// Build option: define BCD_UP_SATURATE_EN to make the counter stop at all-9s
// instead of wrapping to all-0s (OVF still sets, CO unchanged).
// -----------------------------------------------------------------------------
module bcd_up_counter
   import bcd_up_counter_pkg::*;
#(
   parameter int DIGITS = 2
)(
   input  logic                CP,
   input  logic                CR,
   bcd_up_counter_if.slave     bus
);

   localparam int QW = BCD_W * DIGITS;

   logic              cnt_en;
   logic              all_max;
   logic              wrap;
   logic              load_int;
   logic [QW-1:0]     load_val;
   logic [DIGITS-1:0] carry;
   logic [DIGITS-1:0] is_max;
   logic [QW-1:0]     q_vec;
   logic              ovf_q;
   logic              ovf_d;

   assign cnt_en  = bus.Ld & bus.CTP & bus.CTT;
   assign all_max = &is_max;
   assign wrap    = cnt_en & all_max;

`ifdef BCD_UP_SATURATE_EN
   // At all-9s the count turns into a load of all-9s; this also repairs
   // illegal codes that were sitting in the counter.
   assign load_int = ~bus.Ld | wrap;
   assign load_val = bus.Ld ? {DIGITS{BCD_MAX}} : bus.D;
`else
   assign load_int = ~bus.Ld;
   assign load_val = bus.D;
`endif

   // Digit k increments only when every lower digit is at 9 (or above).
   genvar k;
   generate
      for (k = 0; k < DIGITS; k++) begin : g_digit
         if (k == 0) begin : g_c0
            assign carry[k] = cnt_en;
         end else begin : g_ck
            assign carry[k] = carry[k-1] & is_max[k-1];
         end

         bcd_digit_up u_digit (
            .CP         (CP),
            .CR         (CR),
            .load_i     (load_int),
            .load_val_i (load_val[k*BCD_W +: BCD_W]),
            .inc_i      (carry[k]),
            .q_o        (q_vec[k*BCD_W +: BCD_W]),
            .is_max_o   (is_max[k])
         );
      end
   endgenerate

   // Sticky overflow: set by a count at all-9s, cleared only by load or reset.
   always_comb begin
      ovf_d = ovf_q;
      if (!bus.Ld) begin
         ovf_d = 1'b0;
      end else if (wrap) begin
         ovf_d = 1'b1;
      end
   end

   always_ff @(posedge CP or posedge CR) begin
      if (CR) begin
         ovf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.Q   = q_vec;
   assign bus.CO  = bus.CTT & all_max;
   assign bus.OVF = ovf_q;

endmodule

// File: doc/bcd_up_counter.md
Name: bcd_up_counter

Overview:
- Cascadable N-digit BCD up-counter; the counting-up counterpart of the team's BCD down-counter.
- Used for score and elapsed-time tallies in the ball game; the display path reads Q.
- 74161-style control set (Ld, CTP, CTT, CO) so it chains with the existing counters.
- Adds a sticky overflow flag and an optional saturate mode.

Parameters:
- DIGITS, 2, number of BCD digits (1..4); Q width = 4*DIGITS.

Ports:
- CP  input  1  clock; all state updates on posedge.
- CR  input  1  asynchronous reset, active-high.
- Ld  input  1  synchronous load, active-low.
- CTP  input  1  count enable (parallel).
- CTT  input  1  count enable (trickle); also gates CO.
- D  input  4*DIGITS  load value, digit 0 in bits [3:0].
- Q  output  4*DIGITS  counter value (registered).
- CO  output  1  ripple carry to the next stage (combinational).
- OVF  output  1  sticky overflow flag (registered).

Behaviour:
- Reset (CR=1, asynchronous, dominates everything): Q=0, OVF=0. CO is 0 during reset because Q=0.
- Priority at posedge CP when CR=0: Ld=0, then count, then hold.
- Load (Ld=0):
  - Q<=D, OVF<=0.
  - Load ignores CTP/CTT.
  - Non-BCD digits (A..F) are loaded unchanged.
- Count (Ld=1, CTP=1, CTT=1): add one to the BCD value; single-cycle latency.
  - Digit k increments only when all lower digits are 9 (or >9).
  - A digit at 9 wraps to 0 and carries into the next digit.
  - A digit at A..F is treated as 9: it becomes 0 and carries. This gives recovery from illegal loads within one count.
  - Wrap-around from all-9s (e.g. 99 with DIGITS=2) goes to all-0s and sets OVF<=1.
- Hold: either enable low means Q unchanged and OVF unchanged.
- OVF stays 1 until CR=1 or a load.
- CO = CTT & (every digit of Q is 9 or greater).
  - Purely combinational; does not depend on CTP or CP.
  - Cascading: the next stage's CTT connects to this CO, and CTP is shared.
- Simultaneous Ld=0 and count enables: the load wins.
- CR asserted mid-count: Q is cleared immediately (asynchronously). The first count after CR deasserts gives Q=1.
- Glitch-free Q: only registered bits drive Q.

Optional Feature:
- Macro: BCD_UP_SATURATE_EN.
- Defined: at all-9s with the count enabled, Q holds at all-9s instead of wrapping. OVF still sets to 1. CO behaviour is unchanged.
- Undefined: wrap to 0 as described above.

Decomposition:
- Shared package constants:
  - BCD_MAX = 4'd9
  - BCD_ZERO = 4'd0
  - BCD_W = 4
- Typedef bcd_digit_t = logic [3:0], placed beside the down-counter's constants.
- Sub-module bcd_digit_up, instantiated DIGITS times via generate:
  - Inputs: CP, CR, load, load value, inc.
  - Outputs: digit q, is_max (q>=9).
  - The top level builds the inc chain from lower is_max signals and computes CO and OVF.

Test Plan:
1. Reset/count: CR pulse, then Ld=1, CTP=CTT=1 for 12 cycles (DIGITS=2) -> Q steps 00,01..09,10,11,12. At the 09->10 edge, digit0 goes to 0 and digit1 to 1. OVF=0.
2. Wrap: load D=8'h98, count 2 cycles -> Q=99 then Q=00, OVF=1. CO=1 while Q=99 and CTT=1; CO=0 if CTT drops with Q=99.
3. Load priority and OVF clear: with OVF=1, Ld=0, CTP=CTT=1, D=8'h42 -> Q=42, OVF=0. Next cycle with Ld=1 -> Q=43.
4. Enables: Q=17 with CTP=0, CTT=1 for 3 cycles -> Q stays 17, CO=0. Then CTP=1, CTT=0 -> Q stays 17.
5. Illegal digit: load 8'h0C, count once -> Q=10. Load 8'hFF, count once -> Q=00, OVF=1.
6. Async reset and cascade: two instances chained (CO->CTT), counting from 0099; assert CR between clock edges -> Q=0 before the next edge. With BCD_UP_SATURATE_EN: from 99, count 3 -> Q stays 99, OVF=1.
